// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if
//   Bundles the sampler-facing bit stream, the frame configuration and the
//   received-frame results of the UART RX deserializer.
//   master : sampler/host side (drives bits + config, observes results)
//   slave  : deserializer side (consumes bits + config, drives results)
//   Signals:
//     sampled_data, sampled_data_valid  majority-voted bit and its strobe
//     parity_enable, parity_type        frame configuration (0 even, 1 odd)
//     P_DATA, data_valid                received word and its update pulse
//     parity_error, stop_error          per-frame error pulses
//     start_glitch                      start sample read 1 in IDLE
//     busy                              frame in progress
interface uart_rx_deserializer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  sampled_data;
  logic                  sampled_data_valid;
  logic                  parity_enable;
  logic                  parity_type;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;
  logic                  start_glitch;
  logic                  busy;

  modport master (
    output sampled_data, sampled_data_valid, parity_enable, parity_type,
    input  P_DATA, data_valid, parity_error, stop_error, start_glitch, busy
  );

  modport slave (
    input  sampled_data, sampled_data_valid, parity_enable, parity_type,
    output P_DATA, data_valid, parity_error, stop_error, start_glitch, busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   Frame FSM behind the UART RX sampler. Each strobed bit advances the
//   frame: start, DATA_WIDTH data bits LSB-first, optional parity, stop.
//   Good frames update P_DATA with a one-cycle data_valid pulse; errors
//   pulse parity_error / stop_error, and a 1 seen as start pulses
//   start_glitch. All pulses appear one clock after the causing strobe.
//   Ports:
//     clk_based_on_prescale  oversampled RX clock
//     rst_n                  asynchronous active-low reset
//     rx_if                  uart_rx_deserializer_if.slave (bits, config, results)
module uart_rx_deserializer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk_based_on_prescale,
  input  logic                    rst_n,
  uart_rx_deserializer_if.slave   rx_if
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] w_shreg_shift;
  logic [CW-1:0]         r_bit_cnt;
  logic                  r_par_en;
  logic                  r_par_type;
  logic                  r_par_err;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_parity_error;
  logic                  r_stop_error;
  logic                  r_start_glitch;
  logic                  w_busy;
  logic                  w_dv_d;
  logic                  w_perr_d;
  logic                  w_serr_d;
  logic                  w_glitch_d;

  // A 1-bit word has nothing to keep from the old contents.
  if (DATA_WIDTH == 1) begin : g_shift_w1
    assign w_shreg_shift = rx_if.sampled_data;
  end else begin : g_shift_wn
    assign w_shreg_shift = {rx_if.sampled_data, r_shreg[DATA_WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk_based_on_prescale or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: only a strobe can move the FSM
  always_comb begin
    w_next = r_state;
    if (rx_if.sampled_data_valid) begin
      unique case (r_state)
        S_IDLE:   if (!rx_if.sampled_data) w_next = S_DATA;
        S_DATA:   if (r_bit_cnt == LAST_BIT) w_next = r_par_en ? S_PARITY : S_STOP;
        S_PARITY: w_next = S_STOP;
        S_STOP:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Output logic: busy plus the values the pulse registers capture
  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_glitch_d = 1'b0;
    w_serr_d   = 1'b0;
    w_perr_d   = 1'b0;
    w_dv_d     = 1'b0;
    if (rx_if.sampled_data_valid) begin
      if (r_state == S_IDLE) w_glitch_d = rx_if.sampled_data;
      if (r_state == S_STOP) begin
        w_serr_d = !rx_if.sampled_data;
        w_perr_d = r_par_en && r_par_err;
        w_dv_d   = rx_if.sampled_data && !(r_par_en && r_par_err);
      end
    end
  end

  // Datapath and registered pulses
  always_ff @(posedge clk_based_on_prescale or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg        <= '0;
      r_bit_cnt      <= '0;
      r_par_en       <= 1'b0;
      r_par_type     <= 1'b0;
      r_par_err      <= 1'b0;
      r_p_data       <= '0;
      r_data_valid   <= 1'b0;
      r_parity_error <= 1'b0;
      r_stop_error   <= 1'b0;
      r_start_glitch <= 1'b0;
    end else begin
      r_data_valid   <= w_dv_d;
      r_parity_error <= w_perr_d;
      r_stop_error   <= w_serr_d;
      r_start_glitch <= w_glitch_d;
      if (rx_if.sampled_data_valid) begin
        unique case (r_state)
          S_IDLE: begin
            if (!rx_if.sampled_data) begin
              r_par_en   <= rx_if.parity_enable;
              r_par_type <= rx_if.parity_type;
              r_bit_cnt  <= '0;
              r_par_err  <= 1'b0;
            end
          end
          S_DATA: begin
            r_shreg   <= w_shreg_shift;
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
          S_PARITY: r_par_err <= (rx_if.sampled_data != ((^r_shreg) ^ r_par_type));
          S_STOP:   if (w_dv_d) r_p_data <= r_shreg;
          default: ;
        endcase
      end
    end
  end

  assign rx_if.P_DATA       = r_p_data;
  assign rx_if.data_valid   = r_data_valid;
  assign rx_if.parity_error = r_parity_error;
  assign rx_if.stop_error   = r_stop_error;
  assign rx_if.start_glitch = r_start_glitch;
  assign rx_if.busy         = w_busy;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
//   Directed and randomized frames against a frame-level reference model
//   (expected outcome computed from the data word, config and the
//   parity/stop bits actually sent).
module tb_uart_rx_deserializer;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_fail = 0;
  logic [DW-1:0] exp_pdata = '0;

  uart_rx_deserializer_if #(.DATA_WIDTH(DW)) rx_if ();

  uart_rx_deserializer #(.DATA_WIDTH(DW)) dut (
    .clk_based_on_prescale (clk),
    .rst_n                 (rst_n),
    .rx_if                 (rx_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic dv, input logic pe, input logic se,
                          input logic gl, input logic bz);
    chk({tag, ".data_valid"},   32'(rx_if.data_valid),   32'(dv));
    chk({tag, ".parity_error"}, 32'(rx_if.parity_error), 32'(pe));
    chk({tag, ".stop_error"},   32'(rx_if.stop_error),   32'(se));
    chk({tag, ".start_glitch"}, 32'(rx_if.start_glitch), 32'(gl));
    chk({tag, ".busy"},         32'(rx_if.busy),         32'(bz));
    chk({tag, ".P_DATA"},       32'(rx_if.P_DATA),       32'(exp_pdata));
  endtask

  // Called at a negedge; leaves the strobe high for exactly one clock.
  task automatic send_bit(input logic b);
    rx_if.sampled_data       = b;
    rx_if.sampled_data_valid = 1'b1;
    @(negedge clk);
    rx_if.sampled_data_valid = 1'b0;
    rx_if.sampled_data       = 1'($urandom);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_frame(input string tag, input logic [DW-1:0] d, input logic pen,
                            input logic ptype, input logic pbit, input logic stopb,
                            input logic b2b);
    logic exp_par, perr, dv;
    rx_if.parity_enable = pen;
    rx_if.parity_type   = ptype;
    send_bit(1'b0);
    chk_outs({tag, ".start"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < int'(DW); i++) begin
      gap();
      // Config wiggles after start must not matter.
      rx_if.parity_enable = 1'($urandom);
      rx_if.parity_type   = 1'($urandom);
      send_bit(d[i]);
    end
    if (pen) begin
      gap();
      send_bit(pbit);
    end
    gap();
    send_bit(stopb);
    // Reference: the parity bit must make the total count of ones even
    // (even parity) or odd (odd parity).
    exp_par = 1'($countones(d) % 2) ^ ptype;
    perr    = pen && (pbit != exp_par);
    dv      = stopb && !perr;
    if (dv) exp_pdata = d;
    chk_outs({tag, ".end"}, dv, perr, !stopb, 1'b0, 1'b0);
    if (!b2b) begin
      @(negedge clk);
      chk_outs({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rx_if.sampled_data       = 1'b0;
    rx_if.sampled_data_valid = 1'b0;
    rx_if.parity_enable      = 1'b0;
    rx_if.parity_type        = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame("3c_even_ok", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame("3c_even_bad", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame("01_odd_both", 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame("01_odd_stop", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Start sample reads 1: glitch pulse only.
    send_bit(1'b1);
    chk_outs("glitch", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_outs("glitch.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame("5a_after_glitch", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a frame.
    rx_if.parity_enable = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    #2 rst_n = 1'b0;
    exp_pdata = '0;
    #1 chk_outs("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs("midreset.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame("ff_after_reset", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back frames.
    send_frame("b2b_11", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame("b2b_ee", 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized frames, including random parity/stop errors.
    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] d;
      logic pen, ptype, pbit, stopb, b2b;
      d     = DW'($urandom);
      pen   = 1'($urandom);
      ptype = 1'($urandom);
      pbit  = 1'($urandom);
      stopb = ($urandom_range(0, 4) != 0);
      b2b   = 1'($urandom);
      send_frame($sformatf("rand%0d", n), d, pen, ptype, pbit, stopb, b2b);
    end
    @(negedge clk);
    chk_outs("final_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
